// File: rtl/foc_param_table.sv
// Double-buffered FOC parameter table: host writes a shadow bank, commit swaps
// banks at a loop boundary, then the new active bank is copied into the shadow.
module foc_param_table #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD = 2,
  parameter logic [WIDTH*DEPTH-1:0] DEFAULTS =
    ((WIDTH*DEPTH)'(32'hc6800000) << (0 * WIDTH)) |
    ((WIDTH*DEPTH)'(32'h3bd55555) << (1 * WIDTH)) |
    ((WIDTH*DEPTH)'(32'h424cb852) << (10 * WIDTH)) |
    ((WIDTH*DEPTH)'(32'h40c90fdb) << (15 * WIDTH)),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 c,
  input  logic                 rn,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 commit,
  input  logic                 loop_idle,
  output logic                 ready,
  output logic                 dirty,
  output logic                 busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_PEND, S_COPY} state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic                   bank_sel_q, bank_sel_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   ready_q, ready_d;
  logic                   dirty_q, dirty_d;
  logic [NRD*WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [WIDTH-1:0]       mem_q [2][DEPTH];
  logic [WIDTH-1:0]       mem_d [2][DEPTH];
  logic                   wr_fire;
  logic                   wr_in_range;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q    <= S_INIT;
      bank_sel_q <= 1'b0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      dirty_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      dirty_q    <= dirty_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Bank storage carries no reset; INIT rewrites every entry after reset.
  always_ff @(posedge c) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    idx_d       = idx_q;
    ready_d     = ready_q;
    dirty_d     = dirty_q;
    mem_d       = mem_q;
    wr_fire     = (state_q == S_IDLE) && wr_valid;
    wr_in_range = {1'b0, wr_addr} < (AW+1)'(DEPTH);
    case (state_q)
      S_INIT: begin
        mem_d[0][idx_q] = DEFAULTS[idx_q*WIDTH +: WIDTH];
        mem_d[1][idx_q] = DEFAULTS[idx_q*WIDTH +: WIDTH];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          idx_d   = '0;
        end
      end
      S_IDLE: begin
        if (wr_fire && wr_in_range) begin
          if (wr_addr != LAST) begin
            mem_d[~bank_sel_q][wr_addr] = wr_data;
          end
          dirty_d = 1'b1;
        end
        // A write in the commit cycle already counts as pending.
        if (commit && dirty_d) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (loop_idle) begin
          bank_sel_d = ~bank_sel_q;
          dirty_d    = 1'b0;
          idx_d      = '0;
          state_d    = S_COPY;
        end
      end
      S_COPY: begin
        mem_d[~bank_sel_q][idx_q] = mem_q[bank_sel_q][idx_q];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Reads use the registered bank select, so the toggle edge still sees the old bank.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ready_q && ({1'b0, rd_addr[k*AW +: AW]} < (AW+1)'(DEPTH)) &&
          (rd_addr[k*AW +: AW] != LAST)) begin
        rd_data_d[k*WIDTH +: WIDTH] = mem_q[bank_sel_q][rd_addr[k*AW +: AW]];
      end
    end
  end

  always_comb begin
    wr_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    ready    = ready_q;
    dirty    = dirty_q;
    rd_data  = rd_data_q;
  end

endmodule
